fifo_wptr_full_ctrl: RTL and testbench
======================================

// Module: fifo_wptr_full_ctrl
// PURPOSE
//  Write-domain pointer and status controller for the async FIFO; sits directly upstream of the memory.
//  Produces the binary write address and gray write pointer, plus registered full, almost_full, level
//  and a sticky overflow flag. Brings the read gray pointer into wclk through a flop chain for comparison.
// PARAMETERS
//  PTR_WIDTH     3  address bits; pointers are PTR_WIDTH+1 bits wide (extra wrap bit)
//  DEPTH         8  entries; must equal 2**PTR_WIDTH
//  AFULL_THRESH  6  almost_full asserts when level >= this value (1..DEPTH)
//  SYNC_STAGES   2  flops in the g_rptr synchronizer (>=2)
// PORTS
//  wclk         in   1            write clock; the only clock in this block
//  wrst_n       in   1            reset, asynchronous, active-low
//  w_en         in   1            write request from producer
//  ovf_clr      in   1            clears the sticky overflow flag
//  g_rptr       in   PTR_WIDTH+1  gray read pointer from the rclk domain, unsynchronized
//  b_wptr       out  PTR_WIDTH+1  binary write pointer to memory (low PTR_WIDTH bits = address)
//  g_wptr       out  PTR_WIDTH+1  gray write pointer, to the read-domain synchronizer
//  full         out  1            FIFO full, registered
//  almost_full  out  1            level >= AFULL_THRESH, registered
//  wr_level     out  PTR_WIDTH+1  entries occupied as seen from wclk, 0..DEPTH, registered
//  overflow     out  1            sticky: a write was attempted while full
//  w_ack        out  1            combinational: w_en & ~full (write accepted this edge)
// BEHAVIOUR
//  - Reset (wrst_n=0, async): b_wptr=0, g_wptr=0, full=0, almost_full=0, wr_level=0, overflow=0.
//    All sync flops clear to 0. w_ack follows its equation (0 while full=0 and w_en=0).
//  - Sync: g_rptr passes through SYNC_STAGES flops on wclk to give g_rptr_s. No other logic in the chain.
//  - push = w_en & ~full. b_next = b_wptr + push, modulo 2**(PTR_WIDTH+1); wraps from all-ones to 0.
//  - g_next = b_next ^ (b_next >> 1). b_wptr<=b_next and g_wptr<=g_next on every wclk edge.
//  - Only one g_wptr bit changes per accepted write, including on wrap.
//  - full <= (g_next == {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]}).
//    full is valid on the same edge that accepts the DEPTH-th write; the next w_en is refused.
//  - b_rptr_s = gray-to-binary(g_rptr_s), an XOR prefix from the MSB down.
//    wr_level <= b_next - b_rptr_s (modulo PTR_WIDTH+1 bits). almost_full <= (that value >= AFULL_THRESH).
//  - Status is pessimistic: reads reach wclk SYNC_STAGES+1 edges late, so level and full over-report,
//    never under-report. full deasserts only after the synchronized read pointer advances.
//  - overflow: set on an edge with w_en & full; cleared on an edge with ovf_clr; set wins if both occur.
//    A refused write never moves b_wptr or g_wptr.
//  - Reset mid-operation: all outputs drop to reset values immediately, without waiting for wclk.
//    After release, the first synchronized read pointer is valid after SYNC_STAGES edges.
//  - No latches, no combinational path from g_rptr to any output. w_ack is the only combinational output.
// TESTING
//  1 Reset, g_rptr=0, w_en=1 for 8 edges -> b_wptr 1..8, g_wptr=4'b1100, full=1 on 8th edge,
//    wr_level=8, almost_full=1 from the 6th edge.
//  2 Full, w_en=1 for 3 edges -> b_wptr stays 8, w_ack=0, overflow=1 and stays;
//    ovf_clr=1 one edge -> overflow=0.
//  3 Full, drive g_rptr=4'b0110 (bin 4), w_en=0 -> after SYNC_STAGES+1 edges: full=0,
//    wr_level=4, almost_full=0.
//  4 Read tracking writes, 20 pushes -> b_wptr wraps 15->0, g_wptr 1000->0000.
//    Exactly one gray bit toggles per push; no false full.
//  5 wrst_n low between edges mid-burst -> all outputs 0 asynchronously. After release, 1 write -> b_wptr=1, g_wptr=0001.
//  6 Same edge: w_en=1 & full=1 & ovf_clr=1 -> overflow=1. Next edge with ovf_clr=1 only -> overflow=0.

Source files
------------

// File: rtl/fifo_wptr_full_ctrl_if.sv
// fifo_wptr_full_ctrl_if: producer-side handshake and write-domain status bundle
// for the async FIFO write pointer controller.
interface fifo_wptr_full_ctrl_if #(parameter int PTR_WIDTH = 3);
    logic                 w_en;
    logic                 ovf_clr;
    logic [PTR_WIDTH:0]   g_rptr;
    logic [PTR_WIDTH:0]   b_wptr;
    logic [PTR_WIDTH:0]   g_wptr;
    logic                 full;
    logic                 almost_full;
    logic [PTR_WIDTH:0]   wr_level;
    logic                 overflow;
    logic                 w_ack;
    modport master (
        output w_en, ovf_clr, g_rptr,
        input  b_wptr, g_wptr, full, almost_full, wr_level, overflow, w_ack
    );
    modport slave (
        input  w_en, ovf_clr, g_rptr,
        output b_wptr, g_wptr, full, almost_full, wr_level, overflow, w_ack
    );
endinterface

// File: rtl/fifo_wptr_full_ctrl.sv
// fifo_wptr_full_ctrl: write-domain pointer/status controller for the async FIFO.
// Keeps binary and gray write pointers and derives full/level from a synchronized read pointer.
module fifo_wptr_full_ctrl #(
    parameter int PTR_WIDTH    = 3,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6,
    parameter int SYNC_STAGES  = 2
) (
    input logic                  wclk,
    input logic                  wrst_n,
    fifo_wptr_full_ctrl_if.slave bus
);
    localparam int W = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AF_LVL = AFULL_THRESH[PTR_WIDTH:0];
    if (DEPTH != (1 << PTR_WIDTH) || SYNC_STAGES < 2) begin : g_param_check
        $error("fifo_wptr_full_ctrl: DEPTH must be 2**PTR_WIDTH and SYNC_STAGES >= 2");
    end
    logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [PTR_WIDTH:0] g_rptr_s, b_rptr_s;
    logic [PTR_WIDTH:0] b_wptr, g_wptr, wr_level;
    logic [PTR_WIDTH:0] b_next, g_next, level_next;
    logic               full, almost_full, overflow, push;
    assign g_rptr_s = sync_q[SYNC_STAGES-1];
    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    for (genvar k = 0; k <= PTR_WIDTH; k++) begin : g_g2b
        assign b_rptr_s[k] = ^g_rptr_s[PTR_WIDTH:k];
    end
    assign push       = bus.w_en & ~full;
    assign b_next     = b_wptr + W'(push);
    assign g_next     = b_next ^ (b_next >> 1);
    assign level_next = b_next - b_rptr_s;
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.g_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    // Full when the next write pointer sits exactly one wrap ahead of the read pointer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            full        <= g_next == {~g_rptr_s[PTR_WIDTH:PTR_WIDTH-1], g_rptr_s[PTR_WIDTH-2:0]};
            almost_full <= level_next >= AF_LVL;
            wr_level    <= level_next;
            overflow    <= (bus.w_en & full) | (overflow & ~bus.ovf_clr);
        end
    end
    assign bus.b_wptr      = b_wptr;
    assign bus.g_wptr      = g_wptr;
    assign bus.full        = full;
    assign bus.almost_full = almost_full;
    assign bus.wr_level    = wr_level;
    assign bus.overflow    = overflow;
    assign bus.w_ack       = push;
endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// tb_fifo_wptr_full_ctrl: directed bench for the FIFO write-pointer controller.
// Stimulus queues hand-derived expectations; a monitor process checks them each cycle.
module tb_fifo_wptr_full_ctrl;
    typedef struct {
        string      name;
        logic       mid;
        logic       hop;
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] lvl;
        logic       full;
        logic       af;
        logic       ovf;
        logic       ack;
    } exp_t;
    logic wclk = 1'b0;
    logic wrst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    fifo_wptr_full_ctrl_if #(.PTR_WIDTH(3)) bus ();
    fifo_wptr_full_ctrl #(
        .PTR_WIDTH(3), .DEPTH(8), .AFULL_THRESH(6), .SYNC_STAGES(2)
    ) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .bus   (bus)
    );
    always #5 wclk = ~wclk;
    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction
    function automatic exp_t mk(input string nm, input int b, input bit full, input bit af,
                                input int lvl, input bit ovf, input bit ack, input bit mid,
                                input bit hop);
        exp_t e;
        e.name = nm;
        e.b    = 4'(b);
        e.g    = gray(b);
        e.lvl  = 4'(lvl);
        e.full = full;
        e.af   = af;
        e.ovf  = ovf;
        e.ack  = ack;
        e.mid  = mid;
        e.hop  = hop;
        return e;
    endfunction
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask
    // Inputs change just after the falling edge and apply to the following rising edge.
    task automatic step(input logic rst_v, input logic we, input logic clr,
                        input logic [3:0] gr, input exp_t e);
        @(negedge wclk);
        #1;
        wrst_n      = rst_v;
        bus.w_en    = we;
        bus.ovf_clr = clr;
        bus.g_rptr  = gr;
        exp_q.push_back(e);
    endtask
    initial begin : monitor
        exp_t       e;
        logic [3:0] s_b, s_g, s_lvl, prev_g;
        logic       s_full, s_af, s_ovf, s_ack;
        prev_g = '0;
        forever begin
            @(negedge wclk);
            #2;
            s_b = bus.b_wptr; s_g = bus.g_wptr; s_lvl = bus.wr_level;
            s_full = bus.full; s_af = bus.almost_full; s_ovf = bus.overflow; s_ack = bus.w_ack;
            @(posedge wclk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (!e.mid) begin
                    s_b = bus.b_wptr; s_g = bus.g_wptr; s_lvl = bus.wr_level;
                    s_full = bus.full; s_af = bus.almost_full; s_ovf = bus.overflow;
                end
                chk({e.name, ".b_wptr"}, s_b, e.b);
                chk({e.name, ".g_wptr"}, s_g, e.g);
                chk({e.name, ".wr_level"}, s_lvl, e.lvl);
                chk({e.name, ".full"}, {3'b0, s_full}, {3'b0, e.full});
                chk({e.name, ".almost_full"}, {3'b0, s_af}, {3'b0, e.af});
                chk({e.name, ".overflow"}, {3'b0, s_ovf}, {3'b0, e.ovf});
                chk({e.name, ".w_ack"}, {3'b0, s_ack}, {3'b0, e.ack});
                if (e.hop) chk({e.name, ".gray_toggles"}, 4'($countones(bus.g_wptr ^ prev_g)), 4'd1);
            end
            prev_g = bus.g_wptr;
        end
    end
    initial begin : stimulus
        int lvl;
        bus.w_en = 1'b0; bus.ovf_clr = 1'b0; bus.g_rptr = '0;
        step(1'b0, 1'b0, 1'b0, 4'd0, mk("reset", 0, 0, 0, 0, 0, 0, 1, 0));
        step(1'b1, 1'b0, 1'b0, 4'd0, mk("release", 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 8; k++)
            step(1'b1, 1'b1, 1'b0, 4'd0, mk("t1_fill", k, k == 8, k >= 6, k, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, 1'b0, 4'd0, mk("t2_ovf", 8, 1, 1, 8, 1, 0, 0, 0));
        step(1'b1, 1'b0, 1'b1, 4'd0, mk("t2_clr", 8, 1, 1, 8, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++)
            step(1'b1, 1'b0, 1'b0, 4'b0110, mk("t3_wait", 8, 1, 1, 8, 0, 0, 0, 0));
        step(1'b1, 1'b0, 1'b0, 4'b0110, mk("t3_free", 8, 0, 0, 4, 0, 0, 0, 0));
        // Reader follows two writes behind once the synchronizer catches up.
        for (int j = 1; j <= 20; j++) begin
            lvl = (j == 1) ? 5 : (j == 2) ? 6 : 3;
            step(1'b1, 1'b1, 1'b0, gray((8 + j - 1) % 16),
                 mk("t4_wrap", (8 + j) % 16, 0, lvl >= 6, lvl, 0, 1, 0, 1));
        end
        step(1'b0, 1'b1, 1'b0, 4'd0, mk("t5_async", 0, 0, 0, 0, 0, 1, 1, 0));
        step(1'b1, 1'b0, 1'b0, 4'd0, mk("t5_release", 0, 0, 0, 0, 0, 0, 0, 0));
        step(1'b1, 1'b1, 1'b0, 4'd0, mk("t5_write", 1, 0, 0, 1, 0, 1, 0, 0));
        for (int k = 2; k <= 8; k++)
            step(1'b1, 1'b1, 1'b0, 4'd0, mk("t6_fill", k, k == 8, k >= 6, k, 0, 1, 0, 0));
        step(1'b1, 1'b1, 1'b1, 4'd0, mk("t6_set_wins", 8, 1, 1, 8, 1, 0, 0, 0));
        step(1'b1, 1'b0, 1'b1, 4'd0, mk("t6_clear", 8, 1, 1, 8, 0, 0, 0, 0));
        step(1'b1, 1'b0, 1'b0, 4'd0, mk("t6_hold", 8, 1, 1, 8, 0, 0, 0, 0));
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge wclk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
